// File: rtl/pattern_lock_pkg.sv
// Shared types and defaults for the pattern-lock transmitter and receiver.
// Holds the transmitter state set and the default key/preamble values.
package pattern_lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SEND,
    TAIL,
    DONE
  } tx_state_e;

  localparam int         KEY_W_DEF = 3;
  localparam logic [2:0] KEY_DEF   = 3'b110;
  localparam int         PRE_DEF   = 2;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_shreg.sv
// Parallel-load, MSB-first, left-shift key register.
// o_msb_nxt is the MSB the register will hold after the coming edge.
module key_shreg #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_d,
  output logic         o_msb,
  output logic         o_msb_nxt
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift) begin
      r_q <= {r_q[W-2:0], 1'b0};
    end
  end

  always_comb begin
    o_msb_nxt = r_q[W-1];
    if (i_load) begin
      o_msb_nxt = i_d[W-1];
    end else if (i_shift) begin
      o_msb_nxt = r_q[W-2];
    end
  end

  assign o_msb = r_q[W-1];

endmodule

// File: rtl/pattern_key_tx.sv
// Serial key transmitter: zero preamble, MSB-first key, zero tail, done pulse.
// Also issues one-cycle re-lock commands, deferred until idle when busy.
module pattern_key_tx
  import pattern_lock_pkg::*;
#(
  parameter int               PAT_W     = KEY_W_DEF,
  parameter logic [PAT_W-1:0] DEF_KEY   = PAT_W'(KEY_DEF),
  parameter int               PRE_ZEROS = PRE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] key_in,
  input  logic             lock_req,
  output logic             ser_out,
  output logic             lock_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(max_i(PRE_ZEROS, PAT_W) + 1);
  localparam logic [CW-1:0] C_PRE =
    CW'((PRE_ZEROS > 0) ? PRE_ZEROS - 1 : 0);
  localparam logic [CW-1:0] C_BIT = CW'(PAT_W - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  tx_state_e     r_state;
  tx_state_e     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_pend;
  logic          w_pend_nxt;
  logic          w_load;
  logic          w_shift;
  logic          w_lock_nxt;
  logic          w_msb;
  logic          w_msb_nxt;
  logic          r_ser;
  logic          r_lock;
  logic          r_busy;
  logic          r_done;

  key_shreg #(
    .W(PAT_W)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_d      (use_def ? DEF_KEY : key_in),
    .o_msb    (w_msb),
    .o_msb_nxt(w_msb_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_lock_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_pend_nxt = 1'b0;
        // The cycle showing a pulse is a cooldown: lock_req not re-sampled
        if (lock_req) begin
          w_lock_nxt = !r_lock;
        end else if (start) begin
          w_load = 1'b1;
          if (PRE_ZEROS > 0) begin
            w_state_nxt = PRE;
            w_cnt_nxt   = C_PRE;
          end else begin
            w_state_nxt = SEND;
            w_cnt_nxt   = C_BIT;
          end
        end
      end
      PRE: begin
        w_pend_nxt = r_pend | lock_req;
        if (r_cnt == '0) begin
          w_state_nxt = SEND;
          w_cnt_nxt   = C_BIT;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      SEND: begin
        w_pend_nxt = r_pend | lock_req;
        w_shift    = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = TAIL;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      TAIL: begin
        w_pend_nxt  = r_pend | lock_req;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_lock_nxt  = r_pend | lock_req;
        w_pend_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Outputs register the values belonging to the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ser  <= 1'b0;
      r_lock <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_ser  <= (w_state_nxt == SEND) & w_msb_nxt;
      r_lock <= w_lock_nxt;
      r_busy <= (w_state_nxt == PRE) |
                (w_state_nxt == SEND) |
                (w_state_nxt == TAIL);
      r_done <= (w_state_nxt == DONE);
    end
  end

  assign ser_out  = r_ser;
  assign lock_out = r_lock;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/pattern_key_tx.md
Name: pattern_key_tx

Overview:
Serial transmitter for the pattern-lock receiver. On request, it drives an unlock key one bit per clock onto the receiver's serial input. The transmission is framed by a zero preamble and a zero tail so the receiver's detector starts and ends in a known state. It also issues single-cycle re-lock commands to the receiver's Lock input and sits between the control/keypad logic and the lock.

Parameters:
PAT_W, 3, key length in bits (2..16)
DEF_KEY, 3'b110, key used when use_def=1
PRE_ZEROS, 2, preamble zero-bit count (0..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (rst=0 resets)
start  input  1  request a key transmission; sampled in IDLE only
use_def  input  1  sampled with start: 1 sends DEF_KEY, 0 sends key_in
key_in  input  PAT_W  key sampled with start, sent MSB first
lock_req  input  1  request a re-lock pulse
ser_out  output  1  serial key bit to the receiver's data input
lock_out  output  1  one-cycle re-lock command to the receiver
busy  output  1  transmission in progress
done  output  1  one-cycle pulse after the tail bit

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous):
  - state=IDLE; ser_out=0, lock_out=0, busy=0, done=0.
  - Shift register, counter and pending-lock flag are cleared.
  - Applies mid-transmission: the frame is aborted, no done pulse, no pending lock survives.
- States: IDLE, PRE, SEND, TAIL, DONE.
- IDLE:
  - ser_out=0, busy=0.
  - start=1 and lock_req=0: load the shift register with (use_def ? DEF_KEY : key_in). Next state is PRE with cnt=PRE_ZEROS-1, or SEND with cnt=PAT_W-1 when PRE_ZEROS=0.
  - busy=1 from the next cycle.
- PRE: ser_out=0; cnt decrements each cycle; at cnt=0 go to SEND, cnt=PAT_W-1.
- SEND:
  - ser_out=shreg[PAT_W-1]; shift left by one each cycle, filling with 0.
  - At cnt=0 go to TAIL.
- TAIL: ser_out=0 for one cycle; go to DONE.
- DONE: busy=0, done=1 for exactly one cycle; next state IDLE.
- Timing: start accepted at edge 0 gives busy high for PRE_ZEROS+PAT_W+1 cycles (cycles 1..N) and done in cycle N+1.
- start while busy or in DONE: ignored, not queued.
- lock_req:
  - In IDLE with no frame starting: lock_out=1 in the following cycle, for one cycle only. Holding lock_req high gives a pulse every other cycle (pulse cycle counts as IDLE-cooldown; lock_req is re-sampled in the cycle after the pulse).
  - lock_req and start together in IDLE: lock wins, start is dropped, no frame is sent.
  - lock_req while busy or in DONE: sets the pending flag (multiple requests merge into one). lock_out pulses in the first IDLE cycle after DONE; the flag clears with the pulse.
  - lock_out and busy are never high together; lock_out and done are never high together.
- Widths:
  - cnt width = $clog2(max(PRE_ZEROS,PAT_W)+1).
  - The counter never underflows; transitions are decided on cnt==0.

Decomposition:
- Package pattern_lock_pkg holds:
  - the state enum (IDLE, PRE, SEND, TAIL, DONE);
  - the default key 3'b110 and default preamble length 2, shared with the receiver side.
- One sub-module, key_shreg: a parallel-load, MSB-first, left-shift register with load, shift and msb outputs. The FSM, counter and lock logic stay in pattern_key_tx.

Test Plan:
1. Reset: hold rst=0 with start=1 and lock_req=1 -> ser_out=0, lock_out=0, busy=0, done=0 throughout; release rst -> still idle until start is sampled.
2. Default key: use_def=1, start pulsed at cycle 0 -> ser_out over cycles 1..6 = 0,0,1,1,0,0; busy=1 in cycles 1..6; done=1 in cycle 7 only; busy=0 in cycle 7.
3. Custom key with PRE_ZEROS=0 and PAT_W=4: key_in=4'b1011 -> ser_out cycles 1..5 = 1,0,1,1,0; done in cycle 6.
4. Busy behaviour: start re-pulsed at cycle 3 and lock_req pulsed at cycle 4 of case 2 -> single frame unchanged; done in cycle 7; lock_out=1 only in cycle 8.
5. Collision: start=1 and lock_req=1 in the same IDLE cycle 0 -> lock_out=1 in cycle 1; busy stays 0; ser_out stays 0.
6. Mid-frame reset: rst=0 during SEND (cycle 4 of case 2), released at cycle 6 -> outputs 0 immediately (asynchronous); no done pulse; a new start then produces a full 0,0,1,1,0,0 frame.
